// File: rtl/sym_link_pkg.sv
// Shared definitions for the 2-bit symbol link: symbol type, framing
// symbol defaults and the transmitter state encoding. The receiver's
// checker uses the same state enum.
package sym_link_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t START_SYM_DEF = 2'b01;
  localparam sym_t STOP_SYM_DEF  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage : sym_link_pkg

// File: rtl/sym_frame_tx_shreg.sv
// Payload shift register for the symbol transmitter. Loads a whole word,
// shifts right by one symbol per request and exposes the low symbol as a
// tap. With SYM_FRAME_TX_PARITY_EN defined it also keeps a running XOR of
// every symbol shifted out, which equals ^payload once the last data
// symbol has been shifted.
module sym_frame_tx_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
`ifdef SYM_FRAME_TX_PARITY_EN
  output logic              parity,
`endif
  output logic [1:0]        tap
);

  logic [DATA_W-1:0] shreg;

  // Word register: load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= shreg >> 2;
    end
  end

  assign tap = shreg[1:0];

`ifdef SYM_FRAME_TX_PARITY_EN
  logic par_acc;

  // Running parity of the symbols that have left the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc <= 1'b0;
    end else if (load) begin
      par_acc <= 1'b0;
    end else if (shift) begin
      par_acc <= par_acc ^ shreg[1] ^ shreg[0];
    end
  end

  assign parity = par_acc;
`endif

endmodule : sym_frame_tx_shreg

// File: rtl/sym_frame_tx.sv
// Symbol frame transmitter: accepts a DATA_W-bit word over valid/ready and
// sends START, DATA_W/2 data symbols LSB first, an optional PARITY symbol
// (SYM_FRAME_TX_PARITY_EN) and STOP, each over a sym_valid/sym_ready
// handshake.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for a word; in_ready high
//   START  | START_SYM on sym_o, waiting for the receiver to take it
//   DATA   | data symbol on sym_o; count = index of the symbol shown
//   PARITY | {1'b0, ^payload} on sym_o (parity build only)
//   STOP   | STOP_SYM on sym_o; handshake returns to IDLE
module sym_frame_tx
  import sym_link_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter sym_t START_SYM = START_SYM_DEF,
  parameter sym_t STOP_SYM  = STOP_SYM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sym_valid,
  output logic [1:0]        sym_o,
  input  logic              sym_ready,
  output logic              busy
);

  localparam int NSYM  = DATA_W / 2;
  localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [1:0]       sym_o_nxt;
  logic             sym_valid_nxt;
  logic             load, shift;
  logic             accept, sym_hs;
  logic [1:0]       tap;
`ifdef SYM_FRAME_TX_PARITY_EN
  logic             parity;
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign sym_hs   = sym_valid && sym_ready;

  sym_frame_tx_shreg #(
    .DATA_W(DATA_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .load_data(in_data),
`ifdef SYM_FRAME_TX_PARITY_EN
    .parity   (parity),
`endif
    .tap      (tap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next registered outputs and shift register control.
  // Without a symbol handshake nothing advances, which freezes sym_o.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    sym_o_nxt     = sym_o;
    sym_valid_nxt = sym_valid;
    load          = 1'b0;
    shift         = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (accept) begin
          load          = 1'b1;
          state_nxt     = START;
          sym_o_nxt     = START_SYM;
          sym_valid_nxt = 1'b1;
        end
      end
      START: begin
        if (sym_hs) begin
          state_nxt = DATA;
          sym_o_nxt = tap;
          shift     = 1'b1;
        end
      end
      DATA: begin
        if (sym_hs) begin
          if (count == CNT_LAST) begin
`ifdef SYM_FRAME_TX_PARITY_EN
            state_nxt = PARITY;
            sym_o_nxt = {1'b0, parity};
`else
            state_nxt = STOP;
            sym_o_nxt = STOP_SYM;
`endif
          end else begin
            count_nxt = count + 1'b1;
            sym_o_nxt = tap;
            shift     = 1'b1;
          end
        end
      end
`ifdef SYM_FRAME_TX_PARITY_EN
      PARITY: begin
        if (sym_hs) begin
          state_nxt = STOP;
          sym_o_nxt = STOP_SYM;
        end
      end
`endif
      STOP: begin
        if (sym_hs) begin
          state_nxt     = IDLE;
          sym_o_nxt     = 2'b00;
          sym_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        sym_o_nxt     = 2'b00;
        sym_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and symbol counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      sym_o     <= 2'b00;
      sym_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count     <= count_nxt;
      sym_o     <= sym_o_nxt;
      sym_valid <= sym_valid_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule : sym_frame_tx

// File: tb/tb_sym_frame_tx.sv
// Directed bench for sym_frame_tx: an 8-bit instance for the main frame,
// backpressure, back-to-back and reset cases, and a 2-bit instance for the
// minimum width. Expectations follow SYM_FRAME_TX_PARITY_EN when defined.
module tb_sym_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sym_valid, sym_ready, busy;
  logic [7:0] in_data;
  logic [1:0] sym_o;

  logic       in_valid2, in_ready2, sym_valid2, sym_ready2, busy2;
  logic [1:0] in_data2, sym_o2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sym_frame_tx #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sym_valid(sym_valid), .sym_o(sym_o),
    .sym_ready(sym_ready), .busy(busy)
  );

  sym_frame_tx #(.DATA_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .sym_valid(sym_valid2), .sym_o(sym_o2),
    .sym_ready(sym_ready2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one word on the 8-bit instance and checks n symbols (packed
  // LSB-first in exp), then that the link has gone idle.
  task automatic send_frame(input string tag, input logic [7:0] data,
                            input logic [31:0] exp, input int n);
    int guard;
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!(sym_valid && sym_ready) && guard < 50) begin
        tick();
        guard++;
      end
      chk($sformatf("%s_sym%0d", tag, i), {30'd0, sym_o}, exp[2*i +: 2]);
      tick();
    end
    chk($sformatf("%s_end_valid", tag), {31'd0, sym_valid}, 32'd0);
    chk($sformatf("%s_end_busy", tag), {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] exp_b4, exp_01, exp_9c_tail, exp_ff, exp_00_tail, exp_w2;
  int          n_b4, n_01, n_9c_tail, n_ff, n_00_tail, n_w2;
  int          busy_cnt, guard;

  initial begin
`ifdef SYM_FRAME_TX_PARITY_EN
    exp_b4      = {18'd0, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01}; n_b4 = 7;
    exp_01      = {18'd0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01}; n_01 = 7;
    exp_9c_tail = {22'd0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};               n_9c_tail = 5;
    exp_ff      = {18'd0, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01}; n_ff = 7;
    exp_00_tail = {20'd0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};        n_00_tail = 6;
    exp_w2      = {24'd0, 2'b10, 2'b00, 2'b11, 2'b01};                      n_w2 = 4;
`else
    exp_b4      = {20'd0, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};        n_b4 = 6;
    exp_01      = {20'd0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};        n_01 = 6;
    exp_9c_tail = {24'd0, 2'b10, 2'b10, 2'b01, 2'b11};                      n_9c_tail = 4;
    exp_ff      = {20'd0, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};        n_ff = 6;
    exp_00_tail = {22'd0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};               n_00_tail = 5;
    exp_w2      = {26'd0, 2'b10, 2'b11, 2'b01};                             n_w2 = 3;
`endif

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    sym_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_data2   = 2'b00;
    sym_ready2 = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    chk("rst_sym_o", {30'd0, sym_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Frame of 8'hB4 with the receiver always ready.
    send_frame("b4", 8'hB4, exp_b4, n_b4);
    tick();

    // Frame of 8'h01, then the busy window of the same word.
    send_frame("w01", 8'h01, exp_01, n_01);
    tick();
    in_data  = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    busy_cnt = 0;
    guard    = 0;
    while (busy && guard < 40) begin
      busy_cnt++;
      tick();
      guard++;
    end
    chk("w01_busy_cycles", busy_cnt, n_01);
    tick();

    // Backpressure on the second data symbol of 8'h9C (00,11,01,10).
    in_data  = 8'h9C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_start", {30'd0, sym_o}, 32'h1);
    tick();
    chk("bp_d0", {30'd0, sym_o}, 32'h0);
    tick();
    sym_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold_sym%0d", i), {30'd0, sym_o}, 32'h3);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, sym_valid}, 32'd1);
    end
    sym_ready = 1'b1;
    for (int i = 0; i < n_9c_tail; i++) begin
      chk($sformatf("bp_tail%0d", i), {30'd0, sym_o}, exp_9c_tail[2*i +: 2]);
      tick();
    end
    chk("bp_end_valid", {31'd0, sym_valid}, 32'd0);
    tick();

    // in_valid held high across 8'hFF then 8'h00.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < n_ff; i++) begin
      chk($sformatf("b2b_ff_sym%0d", i), {30'd0, sym_o}, exp_ff[2*i +: 2]);
      chk($sformatf("b2b_ff_rdy%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("b2b_gap_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_gap_valid", {31'd0, sym_valid}, 32'd0);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_00_start", {30'd0, sym_o}, 32'h1);
    chk("b2b_00_valid", {31'd0, sym_valid}, 32'd1);
    tick();
    for (int i = 0; i < n_00_tail; i++) begin
      chk($sformatf("b2b_00_sym%0d", i), {30'd0, sym_o}, exp_00_tail[2*i +: 2]);
      tick();
    end
    chk("b2b_00_end_valid", {31'd0, sym_valid}, 32'd0);
    tick();

    // Reset in the middle of the data phase.
    in_data  = 8'hB4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, sym_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rel_valid", {31'd0, sym_valid}, 32'd0);
    send_frame("after_rst", 8'h01, exp_01, n_01);
    tick();

    // Minimum width instance, word 2'b11.
    in_data2  = 2'b11;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < n_w2; i++) begin
      chk($sformatf("w2_sym%0d", i), {30'd0, sym_o2}, exp_w2[2*i +: 2]);
      chk($sformatf("w2_valid%0d", i), {31'd0, sym_valid2}, 32'd1);
      tick();
    end
    chk("w2_end_valid", {31'd0, sym_valid2}, 32'd0);
    chk("w2_end_busy", {31'd0, busy2}, 32'd0);
    chk("w2_end_ready", {31'd0, in_ready2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sym_frame_tx
